// File: rtl/ipc_pkg.sv
// Shared state encoding and timing defaults for the IPC serial link.
package ipc_pkg;

    localparam int unsigned IpcTLow    = 16;
    localparam int unsigned IpcTHigh   = 16;
    localparam int unsigned IpcTimeout = 65535;

    typedef enum logic [2:0] {
        StIdle,
        StP1Low,
        StP1High,
        StSample,
        StP2Low,
        StP2High
    } ipc_state_e;

    // Bits needed for a counter running 0 .. n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ipc_link_pulse.sv
// One comctrl pulse: low for T_LOW cycles, then high for T_HIGH cycles.
module ipc_link_pulse
    import ipc_pkg::*;
#(
    parameter int unsigned T_LOW  = IpcTLow,
    parameter int unsigned T_HIGH = IpcTHigh
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic start,
    output logic ctrl,
    output logic low_end,
    output logic done
);

    localparam int unsigned CntW = cnt_width((T_LOW > T_HIGH) ? T_LOW : T_HIGH);

    typedef enum logic [1:0] {PhIdle, PhLow, PhHigh} phase_e;

    phase_e          phase_q;
    logic [CntW-1:0] cnt_q;

    assign low_end = (phase_q == PhLow)  && (cnt_q == CntW'(T_LOW - 1));
    assign done    = (phase_q == PhHigh) && (cnt_q == CntW'(T_HIGH - 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PhIdle;
            cnt_q   <= '0;
            ctrl    <= 1'b1;
        end else begin
            unique case (phase_q)
                PhIdle: begin
                    if (start) begin
                        phase_q <= PhLow;
                        cnt_q   <= '0;
                        ctrl    <= 1'b0;
                    end
                end
                PhLow: begin
                    if (low_end) begin
                        phase_q <= PhHigh;
                        cnt_q   <= '0;
                        ctrl    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PhHigh: begin
                    if (done) begin
                        phase_q <= PhIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    phase_q <= PhIdle;
                    ctrl    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/ipc_link.sv
// IPC side of a bit-serial host link: one host bit per two comctrl pulses, reply MSB first.
// Define IPC_LINK_TIMEOUT_EN to abort partial bytes after TIMEOUT idle cycles (drives rx_err).
module ipc_link
    import ipc_pkg::*;
#(
    parameter int unsigned T_LOW   = IpcTLow,
    parameter int unsigned T_HIGH  = IpcTHigh,
    parameter int unsigned TIMEOUT = IpcTimeout
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    output logic       comctrl,
    input  logic       comdata_in,
    output logic       comdata_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_busy,
    output logic       rx_err
);

    ipc_state_e state_q;
    logic [1:0] sync_q;
    logic       din_s;
    logic       start_seen_q;
    logic       pulse_start;
    logic       low_end;
    logic       pulse_done;
    logic       timeout_hit;
    logic [7:0] rx_shift_q;
    logic [7:0] tx_shift_q;
    logic [2:0] rx_cnt_q;
    logic [2:0] tx_cnt_q;
    logic       rx_full_q;
    logic       tx_last_q;
    logic       tx_arm_q;

    assign din_s       = sync_q[1];
    assign pulse_start = ((state_q == StIdle) && !din_s && start_seen_q) || (state_q == StSample);

    ipc_link_pulse #(
        .T_LOW  (T_LOW),
        .T_HIGH (T_HIGH)
    ) u_pulse (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .start   (pulse_start),
        .ctrl    (comctrl),
        .low_end (low_end),
        .done    (pulse_done)
    );

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            sync_q       <= 2'b11;
            start_seen_q <= 1'b0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            rx_cnt_q     <= '0;
            tx_cnt_q     <= '0;
            rx_full_q    <= 1'b0;
            tx_last_q    <= 1'b0;
            tx_arm_q     <= 1'b0;
            comdata_out  <= 1'b1;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            tx_busy      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], comdata_in};
            rx_valid     <= 1'b0;
            start_seen_q <= (state_q == StIdle) && !din_s;

            if (tx_load && !tx_busy) begin
                tx_shift_q <= tx_data;
                tx_busy    <= 1'b1;
                tx_cnt_q   <= '0;
            end

            unique case (state_q)
                StIdle: begin
                    if (!din_s && start_seen_q) begin
                        state_q  <= StP1Low;
                        // A reply only drives slots that begin after it was loaded.
                        tx_arm_q <= tx_busy;
                    end
                end
                StP1Low:  if (low_end)    state_q <= StP1High;
                StP1High: if (pulse_done) state_q <= StSample;
                StSample: begin
                    rx_shift_q <= {rx_shift_q[6:0], din_s};
                    rx_cnt_q   <= rx_cnt_q + 1'b1;
                    rx_full_q  <= (rx_cnt_q == 3'd7);
                    if (tx_arm_q) begin
                        comdata_out <= tx_shift_q[7];
                        tx_shift_q  <= {tx_shift_q[6:0], 1'b1};
                        tx_cnt_q    <= tx_cnt_q + 1'b1;
                        tx_last_q   <= (tx_cnt_q == 3'd7);
                    end
                    state_q <= StP2Low;
                end
                StP2Low: begin
                    if (low_end) begin
                        state_q     <= StP2High;
                        comdata_out <= 1'b1;
                    end
                end
                StP2High: begin
                    if (pulse_done) begin
                        state_q <= StIdle;
                        if (rx_full_q) begin
                            rx_data   <= rx_shift_q;
                            rx_valid  <= 1'b1;
                            rx_full_q <= 1'b0;
                        end
                        if (tx_last_q) begin
                            tx_busy   <= 1'b0;
                            tx_last_q <= 1'b0;
                            tx_arm_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (timeout_hit) begin
                rx_cnt_q  <= '0;
                tx_cnt_q  <= '0;
                tx_busy   <= 1'b0;
                tx_last_q <= 1'b0;
                tx_arm_q  <= 1'b0;
            end
        end
    end

`ifdef IPC_LINK_TIMEOUT_EN
    localparam int unsigned ToW = cnt_width(TIMEOUT);

    logic [ToW-1:0] idle_cnt_q;
    logic           rx_err_q;
    logic           idle_partial;

    assign idle_partial = (state_q == StIdle) && (rx_cnt_q != 3'd0);
    assign timeout_hit  = idle_partial && (idle_cnt_q == ToW'(TIMEOUT - 1));
    assign rx_err       = rx_err_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_q <= '0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_err_q <= timeout_hit;
            if (idle_partial && !timeout_hit) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end else begin
                idle_cnt_q <= '0;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign rx_err         = 1'b0;
`endif

endmodule

// File: tb/tb_ipc_link.sv
// Scoreboard bench for ipc_link driving a 4-bit shift-register host model.
module tb_ipc_link;

    localparam int unsigned TL = 4;
    localparam int unsigned TH = 6;
    localparam int unsigned TO = 100;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       comctrl;
    logic       comdata_in;
    logic       comdata_out;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_busy;
    logic       rx_err;

    int errors = 0;
    int checks = 0;
    int falls  = 0;

    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    logic       err_exp[$];

    logic [7:0] rx_acc = 8'h00;
    int         rx_n = 0;
    logic [7:0] host_rd = 8'h00;
    logic       saw_low = 1'b0;
    logic       busy_prev = 1'b0;
    logic [7:0] exp_b;

    ipc_link #(
        .T_LOW   (TL),
        .T_HIGH  (TH),
        .TIMEOUT (TO)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .comctrl     (comctrl),
        .comdata_in  (comdata_in),
        .comdata_out (comdata_out),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_busy     (tx_busy),
        .rx_err      (rx_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge comctrl) if (reset_n) falls++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents an output event.
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (rx_valid) begin
                if (rx_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx_unexpected: rx_data=%02h with no byte expected", rx_data);
                end else begin
                    exp_b = rx_exp.pop_front();
                    check("rx_byte", {24'h0, rx_data}, {24'h0, exp_b});
                end
            end
            if (rx_err) begin
                checks++;
                if (err_exp.size() == 0) begin
                    errors++;
                    $display("FAIL rx_err_unexpected: rx_err=1, required 0");
                end else begin
                    void'(err_exp.pop_front());
                end
            end
            if (busy_prev && !tx_busy) begin
                if (tx_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_done_unexpected: host read %02h, no reply expected", host_rd);
                end else begin
                    exp_b = tx_exp.pop_front();
                    check("host_read", {24'h0, host_rd}, {24'h0, exp_b});
                end
            end
            if (!comdata_out) saw_low = 1'b1;
        end
        busy_prev = tx_busy;
    end

    task automatic model_bit(input logic d);
        rx_acc = {rx_acc[6:0], d};
        rx_n++;
        if (rx_n == 8) begin
            rx_exp.push_back(rx_acc);
            rx_n = 0;
        end
    endtask

    task automatic wait_fall(input string what);
        logic prev;
        bit   found;
        found = 1'b0;
        prev  = comctrl;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk_sys);
            #1;
            if (prev && !comctrl) found = 1'b1;
            prev = comctrl;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: no comctrl falling edge within 200 cycles", what);
        end
    endtask

    // One host slot: start bit, D on 1st falling edge, latch reply and idle on 2nd.
    task automatic slot(input logic d, input logic ld, input logic [7:0] ld_val);
        model_bit(d);
        comdata_in = 1'b0;
        wait_fall("slot_edge1");
        comdata_in = d;
        if (ld) begin
            tx_data = ld_val;
            tx_load = 1'b1;
            @(posedge clk_sys);
            #1;
            tx_load = 1'b0;
        end
        wait_fall("slot_edge2");
        host_rd    = {host_rd[6:0], comdata_in & comdata_out};
        comdata_in = 1'b1;
        repeat (TL + TH + 4) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) slot(b[i], 1'b0, 8'h00);
    endtask

    task automatic load(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        @(posedge clk_sys);
        #1;
        tx_load = 1'b0;
    endtask

    initial begin
        int f0;
        reset_n    = 1'b0;
        comdata_in = 1'b1;
        tx_data    = 8'h00;
        tx_load    = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_comctrl", {31'h0, comctrl}, 32'h1);
        check("rst_comdata_out", {31'h0, comdata_out}, 32'h1);
        check("rst_rx_data", {24'h0, rx_data}, 32'h0);
        check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_tx_busy", {31'h0, tx_busy}, 32'h0);
        check("rst_rx_err", {31'h0, rx_err}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;

        // Host write of 0xA5: two comctrl falls per bit.
        f0 = falls;
        send_byte(8'hA5);
        check("falls_per_byte", falls - f0, 32'd16);

        // Reply 0x3C over 8 read slots.
        load(8'h3C);
        tx_exp.push_back(8'h3C);
        check("tx_busy_after_load", {31'h0, tx_busy}, 32'h1);
        for (int i = 0; i < 7; i++) slot(1'b1, 1'b0, 8'h00);
        check("tx_busy_slot7", {31'h0, tx_busy}, 32'h1);
        slot(1'b1, 1'b0, 8'h00);
        check("tx_busy_slot8", {31'h0, tx_busy}, 32'h0);

        // No reply loaded: host reads all ones.
        saw_low = 1'b0;
        for (int i = 0; i < 8; i++) slot(1'b1, 1'b0, 8'h00);
        check("idle_read", {24'h0, host_rd}, 32'hFF);
        check("idle_no_low", {31'h0, saw_low}, 32'h0);

        // Load mid-slot, second load while busy is dropped.
        tx_exp.push_back(8'h55);
        slot(1'b1, 1'b1, 8'h55);
        slot(1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 7; i++) slot(1'b1, 1'b0, 8'h00);
        check("tx_busy_after_55", {31'h0, tx_busy}, 32'h0);

        // Reset during P1 low of the 4th bit.
        slot(1'b1, 1'b0, 8'h00);
        slot(1'b0, 1'b0, 8'h00);
        slot(1'b1, 1'b0, 8'h00);
        comdata_in = 1'b0;
        wait_fall("partial_edge1");
        check("mid_pulse_low", {31'h0, comctrl}, 32'h0);
        reset_n = 1'b0;
        #1;
        check("rst_release_comctrl", {31'h0, comctrl}, 32'h1);
        check("rst_no_rx_valid", {31'h0, rx_valid}, 32'h0);
        comdata_in = 1'b1;
        rx_acc     = 8'h00;
        rx_n       = 0;
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;
        send_byte(8'h81);

        // Partial byte then a long stall.
        slot(1'b1, 1'b0, 8'h00);
        slot(1'b0, 1'b0, 8'h00);
        slot(1'b1, 1'b0, 8'h00);
`ifdef IPC_LINK_TIMEOUT_EN
        err_exp.push_back(1'b1);
        rx_acc = 8'h00;
        rx_n   = 0;
`endif
        repeat (TO + 21) @(posedge clk_sys);
        #1;
        send_byte(8'h0F);

        repeat (20) @(posedge clk_sys);
        #1;
        check("rx_queue_drained", rx_exp.size(), 32'd0);
        check("tx_queue_drained", tx_exp.size(), 32'd0);
        check("err_queue_drained", err_exp.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ipc_link.md
IPC_LINK -- requirements
Module: ipc_link

Interface
REQ-001 SHALL have parameter T_LOW, default 16: clk_sys cycles COMCTL is held low per pulse.
REQ-002 SHALL have parameter T_HIGH, default 16: clk_sys cycles COMCTL is held high after each pulse before the next action.
REQ-003 SHALL have parameter TIMEOUT, default 65535: maximum idle cycles between bits of one byte (used only under REQ-024).
REQ-004 SHALL have ports: clk_sys in 1, the single clock; reset_n in 1, asynchronous active-low reset.
REQ-005 SHALL have ports: comctrl out 1, idle high, low pulses shift the host bit register; comdata_in in 1, host serial bit; comdata_out out 1, IPC reply bit, idle high.
REQ-006 SHALL have ports: rx_data out 8, assembled host byte; rx_valid out 1, one-cycle strobe when rx_data is updated.
REQ-007 SHALL have ports: tx_data in 8, reply byte; tx_load in 1, strobe capturing tx_data; tx_busy out 1, high while a loaded reply is not fully sent.
REQ-008 SHALL have ports: rx_err out 1, one-cycle strobe on an aborted byte (low when REQ-024 is compiled out).

Function
REQ-009 SHALL sample comdata_in through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-010 SHALL implement states IDLE, P1_LOW, P1_HIGH, SAMPLE, P2_LOW, P2_HIGH.
REQ-011 IDLE: the FSM SHALL go to P1_LOW when the synchronised comdata_in is 0 (start bit) for two consecutive cycles.
REQ-012 P1_LOW: comctrl=0 for T_LOW cycles, then P1_HIGH: comctrl=1 for T_HIGH cycles, then SAMPLE.
REQ-013 SAMPLE (one cycle): the FSM SHALL shift synchronised comdata_in MSB-first into the rx shift register. If tx_busy=1, it SHALL drive comdata_out to the current tx bit, MSB first. It SHALL then enter P2_LOW.
REQ-014 P2_LOW and P2_HIGH SHALL time like P1. comdata_out SHALL hold its value through P2_LOW and return to 1 on entry to P2_HIGH. After P2_HIGH the FSM SHALL return to IDLE.
REQ-015 Exactly two comctrl falling edges SHALL occur per bit; the host busy flag therefore clears after P2_LOW.
REQ-016 After the 8th SAMPLE, rx_data SHALL update and rx_valid SHALL pulse on the cycle P2_HIGH ends; the bit counter SHALL wrap 7->0.
REQ-017 If tx_busy=0 at SAMPLE, comdata_out SHALL stay 1 (the host reads 0xFF).
REQ-018 After the 8th transmitted bit, tx_busy SHALL clear at the end of that bit's P2_HIGH.
REQ-019 tx_load while tx_busy=1 SHALL be ignored. tx_load while tx_busy=0 SHALL capture tx_data and set tx_busy the next cycle. tx bit alignment SHALL start at the next bit slot.
REQ-020 A start bit arriving while not in IDLE SHALL NOT be recognised until IDLE is re-entered; no bit is double-counted.
REQ-021 Simultaneous tx_load and SAMPLE: the new byte SHALL take effect only from the next bit slot.

Reset
REQ-022 While reset_n=0: comctrl=1, comdata_out=1, rx_data=0x00, rx_valid=0, tx_busy=0, rx_err=0, bit counters=0, state=IDLE, synchroniser=1s.
REQ-023 Reset assertion mid-pulse SHALL immediately release comctrl high. No rx_valid or rx_err SHALL be generated for the partial byte.

Configuration
REQ-024 With IPC_LINK_TIMEOUT_EN defined, a counter SHALL run in IDLE while the bit counter is nonzero. Reaching TIMEOUT SHALL clear the rx and tx bit counters and tx_busy, and pulse rx_err for one cycle. Without the macro, no counter exists, partial bytes wait indefinitely, and rx_err is tied 0.

Structure
REQ-025 Package ipc_pkg SHALL hold the state enum and the default T_LOW, T_HIGH and TIMEOUT constants.
REQ-026 Sub-module ipc_link_pulse SHALL generate one low/high comctrl pulse on a start strobe and return a done strobe. ipc_link SHALL instantiate it once and reuse it for P1 and P2.

Verification
REQ-027 Host model shifts 4-bit XEDS on comctrl falling edges; 8 writes carrying D bits of 0xA5 -> 16 comctrl falling edges, rx_data=0xA5, one rx_valid pulse.
REQ-028 tx_load with 0x3C, then 8 host read slots (D=1) latching comdata_in AND comdata_out on the 2nd edge -> host assembles 0x3C; tx_busy clears after the 8th slot.
REQ-029 8 read slots with no tx_load -> host assembles 0xFF and comdata_out never goes low.
REQ-030 tx_load of 0x55 during a slot, then tx_load of 0x00 while busy -> host reads 0x55 from the next 8 slots; 0x00 is ignored.
REQ-031 Assert reset_n=0 during P1_LOW of bit 3 -> comctrl=1 within the same cycle, no rx_valid, and the next full byte 0x81 is received correctly.
REQ-032 With IPC_LINK_TIMEOUT_EN and TIMEOUT=100, send 3 bits and stall 101 cycles -> rx_err pulse; the following 8 bits of 0x0F give rx_data=0x0F.
